// File: rtl/led_disp_pkg.sv
// led_disp_pkg: shared 7-segment constants (glyph table, blank code, segment bit positions).
package led_disp_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;
  // Active-low {a,b,c,d,e,f,g,dp} patterns for hex 0..F, dp off
  localparam logic [7:0] GLYPH [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h05, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71
  };
endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational hex digit to active-low segment pattern lookup.
module seg_glyph_rom
  import led_disp_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [7:0] o_seg
);
  assign o_seg = GLYPH[i_hex];
endmodule

// File: rtl/led_scan_driver.sv
// led_scan_driver: multiplexed 7-segment scan driver with frame-synchronous updates.
// Define LED_DIM_EN to add a brightness input and PWM dimming of the anodes.
module led_scan_driver
  import led_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
`ifdef LED_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_start
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_data, r_pend_data;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
  logic                    r_ready;
  logic                    w_tc, w_last, w_boundary, w_guard, w_upper_nz, w_show, w_duty;
  logic [3:0]              w_hex;
  logic [7:0]              w_glyph, w_seg;

  assign w_tc       = r_presc == PW'(REFRESH_DIV - 1);
  assign w_last     = r_idx == IW'(NUM_DIGITS - 1);
  assign w_boundary = w_tc && w_last;
  assign w_hex      = r_act_data[4*r_idx +: 4];
  assign wr_ready   = r_ready;

  if (GUARD == 0) begin : g_no_guard
    assign w_guard = 1'b0;
  end else begin : g_guard
    assign w_guard = r_presc < PW'(GUARD);
  end

`ifdef LED_DIM_EN
  logic [3:0] r_pwm;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pwm <= '0;
    else        r_pwm <= r_pwm + 1'b1;
  assign w_duty = r_pwm <= brightness;
`else
  assign w_duty = 1'b1;
`endif

  // A digit is a leading zero only if it and every digit above it are zero
  always_comb begin
    w_upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(r_idx) && r_act_data[4*j +: 4] != 4'h0) w_upper_nz = 1'b1;
  end

  assign w_show = digit_en[r_idx] && !(lz_blank && r_idx != '0 && !w_upper_nz);

  seg_glyph_rom u_rom (.i_hex(w_hex), .o_seg(w_glyph));

  always_comb begin
    w_seg         = w_glyph;
    w_seg[SEG_DP] = ~r_act_dp[r_idx];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_ready     <= 1'b1;
      an          <= '1;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + 1'b1;
      if (w_tc) r_idx <= w_last ? '0 : r_idx + 1'b1;
      // Transfer needs ready=1 and commit needs ready=0, so a same-cycle
      // transfer waits for the following boundary
      if (wr_valid && r_ready) begin
        r_pend_data <= wr_data;
        r_pend_dp   <= wr_dp;
        r_ready     <= 1'b0;
      end else if (w_boundary && !r_ready) begin
        r_act_data <= r_pend_data;
        r_act_dp   <= r_pend_dp;
        r_ready    <= 1'b1;
      end
      an          <= (w_show && !w_guard && w_duty) ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      seg         <= (w_show && !w_guard) ? w_seg : SEG_BLANK;
      frame_start <= r_presc == '0 && r_idx == '0;
    end
endmodule
